// File: rtl/lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pipe -- load/store unit: dmem handshake FSM + zero-latency io
//            window. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0
// ============================================================================
module lsu_pipe #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DMEM_BASE = 16'h2000,
  parameter int unsigned DMEM_SIZE = 16'h2000,
  parameter int unsigned IO_BASE   = 16'h7000,
  parameter int unsigned IO_SIZE   = 16'h1000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_req,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_lsu_op,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  output logic [31:0]       o_ld_data,
  output logic              o_stall,
  output logic              o_err,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  output logic              o_mem_rden,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_io_addr,
  output logic [31:0]       o_io_wdata,
  output logic [3:0]        o_io_bmask,
  output logic              o_io_wren,
  input  logic [31:0]       i_io_rdata
);

  localparam int unsigned CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [31:0] C_ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << ADDR_W) - 64'd1);
  localparam logic [1:0]  C_SZ_BYTE   = 2'b00;
  localparam logic [1:0]  C_SZ_HALF   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_ld_data;
  logic [2:0]       r_op;
  logic [1:0]       r_lane;
  logic             r_err;

  logic [1:0]  w_size;
  logic [31:0] w_addr_raw;
  logic [31:0] w_addr;
  logic        w_dmem_hit;
  logic        w_io_hit;
  logic        w_trap;
  logic        w_act;
  logic [31:0] w_wdata;
  logic [3:0]  w_bmask;

  // Shift the addressed lane down, then sign- or zero-extend by funct3.
  function automatic logic [31:0] f_load_ext(input logic [2:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (op[1:0])
      2'b00:   f_load_ext = op[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_load_ext = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: f_load_ext = word;
    endcase
  endfunction

  assign w_size     = i_lsu_op[1:0];
  assign w_addr_raw = i_lsu_addr & C_ADDR_MASK;

  // Misaligned accesses are truncated to natural alignment; with the trap
  // enabled they never reach a strobe, so the truncation is harmless there.
  always_comb begin
    w_addr = w_addr_raw;
    if (w_size == C_SZ_HALF)      w_addr[0]   = 1'b0;
    else if (w_size != C_SZ_BYTE) w_addr[1:0] = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal    = ((w_size == C_SZ_HALF) && w_addr_raw[0]) ||
                      ((w_size != C_SZ_HALF) && (w_size != C_SZ_BYTE) && (w_addr_raw[1:0] != 2'b00));
  assign w_trap     = i_lsu_req & w_misal;
  assign o_misalign = i_rst_n & i_lsu_req & (r_state == ST_IDLE) & w_misal;
`else
  assign w_trap     = 1'b0;
  assign o_misalign = 1'b0;
`endif

  assign w_dmem_hit = (w_addr >= DMEM_BASE) && (w_addr < DMEM_BASE + DMEM_SIZE);
  assign w_io_hit   = (w_addr >= IO_BASE)   && (w_addr < IO_BASE + IO_SIZE);
  // Only a request seen in IDLE is acted upon; DONE still shows the old one.
  assign w_act      = i_rst_n & i_lsu_req & (r_state == ST_IDLE) & ~w_trap;

  always_comb begin
    case (w_size)
      C_SZ_BYTE: begin
        w_wdata = {24'h0, i_st_data[7:0]} << {w_addr[1:0], 3'b000};
        w_bmask = 4'b0001 << w_addr[1:0];
      end
      C_SZ_HALF: begin
        w_wdata = {16'h0, i_st_data[15:0]} << {w_addr[1], 4'b0000};
        w_bmask = 4'b0011 << {w_addr[1], 1'b0};
      end
      default: begin
        w_wdata = i_st_data;
        w_bmask = 4'b1111;
      end
    endcase
  end

  assign o_io_addr  = ADDR_W'(w_addr - IO_BASE);
  assign o_io_wdata = w_wdata;
  assign o_io_bmask = w_bmask;
  assign o_io_wren  = w_act & i_lsu_wren & w_io_hit;
  assign o_stall    = (w_act & w_dmem_hit) | (r_state == ST_WAIT);
  assign o_err      = (w_act & ~i_lsu_wren & ~w_dmem_hit & ~w_io_hit) | r_err;

  always_comb begin
    o_ld_data = '0;
    if (r_state == ST_DONE)
      o_ld_data = r_ld_data;
    else if (w_act && !i_lsu_wren && w_io_hit)
      o_ld_data = f_load_ext(i_lsu_op, w_addr[1:0], i_io_rdata);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ld_data   <= '0;
      r_op        <= '0;
      r_lane      <= '0;
      r_err       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_rden  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_act && w_dmem_hit) begin
            o_mem_addr  <= ADDR_W'((w_addr - DMEM_BASE) >> 2);
            o_mem_wdata <= w_wdata;
            o_mem_bmask <= w_bmask;
            o_mem_wren  <= i_lsu_wren;
            o_mem_rden  <= ~i_lsu_wren;
            r_op        <= i_lsu_op;
            r_lane      <= w_addr[1:0];
            r_cnt       <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            r_ld_data  <= o_mem_rden ? f_load_ext(r_op, r_lane, i_mem_rdata) : 32'h0;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;
            r_state    <= ST_DONE;
          end else if (r_cnt == C_TIMEOUT) begin
            r_ld_data  <= '0;
            r_err      <= 1'b1;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
